// File: rtl/store_buffer.sv
// Posted-write FIFO between the CPU memory port and dmem. Stores retire in one cycle
// and drain to dmem when the port is idle; loads snoop the queue for the youngest match.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_hit,
  output logic [DATA_W-1:0]        ld_data,
  input  logic                     mem_busy,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_adr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;

  logic push, pop;

  // Outputs that would otherwise read as "ready" from a zeroed counter are gated by reset.
  assign empty    = !reset || (count_q == '0);
  assign st_ready = reset && (count_q < CNT_W'(DEPTH));
  assign mem_we   = !empty && !mem_busy;
  assign mem_adr   = empty ? '0 : addr_q[head_q];
  assign mem_wdata = empty ? '0 : data_q[head_q];
  assign count    = count_q;

  assign push = st_valid && st_ready;
  assign pop  = mem_we;

  // Control state: pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let push and pop both read the pre-edge valid_q and pointers.
      if (push) begin
        tail_q          <= tail_q + PTR_W'(1);
        valid_q[tail_q] <= 1'b1;
      end
      if (pop) begin
        head_q          <= head_q + PTR_W'(1);
        valid_q[head_q] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: entry payload is not reset; valid_q alone decides whether an entry is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= st_data;
    end
  end

  // Snoop walks oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    // NOTE: defaults first so every path assigns ld_hit/ld_data and no latch is inferred.
    ld_hit  = 1'b0;
    ld_data = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (valid_q[idx] && (addr_q[idx] == ld_addr)) begin
        ld_hit  = 1'b1;
        ld_data = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drives stimulus 1 ns after each rising edge,
// checks combinational outputs 1 ns later, and logs every dmem write for order checks.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [19:0] st_addr;
  logic [31:0] st_data;
  logic [19:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        mem_busy;
  logic        mem_we;
  logic [19:0] mem_adr;
  logic [31:0] mem_wdata;
  logic        empty;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [19:0] adr;
    logic [31:0] data;
  } wr_t;
  wr_t wr_log[$];

  store_buffer #(.DEPTH(4), .ADDR_W(20), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .mem_busy(mem_busy), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  // dmem model: records every write strobe seen at a rising edge.
  always @(posedge clk) begin
    if (reset && mem_we) wr_log.push_back('{adr: mem_adr, data: mem_wdata});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic expect_log(input string tag, input int idx, input logic [19:0] adr,
                            input logic [31:0] data);
    if (wr_log.size() > idx) begin
      check({tag, "_adr"},  64'(wr_log[idx].adr),  64'(adr));
      check({tag, "_data"}, 64'(wr_log[idx].data), 64'(data));
    end else begin
      check({tag, "_present"}, 64'(wr_log.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    ld_addr  = '0;
    mem_busy = 1'b0;

    // 1. reset behaviour
    #2;
    check("rst_ready", st_ready, 0);
    check("rst_empty", empty, 1);
    check("rst_we", mem_we, 0);
    tick(); tick();
    reset = 1'b1;
    tick();
    check("idle_ready", st_ready, 1);
    check("idle_empty", empty, 1);
    check("idle_we", mem_we, 0);
    check("idle_count", count, 0);
    check("idle_hit", ld_hit, 0);

    // 2. single store, snoop, drain
    mem_busy = 1'b1;
    st_valid = 1'b1; st_addr = 20'h00010; st_data = 32'hDEADBEEF;
    ld_addr  = 20'h00010;
    settle();
    check("t2_hit_same_cycle", ld_hit, 0);
    tick();
    st_valid = 1'b0;
    settle();
    check("t2_count", count, 1);
    check("t2_hit", ld_hit, 1);
    check("t2_ld_data", ld_data, 32'hDEADBEEF);
    check("t2_busy_we", mem_we, 0);
    mem_busy = 1'b0;
    settle();
    check("t2_we", mem_we, 1);
    check("t2_adr", mem_adr, 20'h00010);
    check("t2_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    check("t2_empty", empty, 1);
    check("t2_we_after", mem_we, 0);
    check("t2_nwrites", wr_log.size(), 1);
    expect_log("t2_w0", 0, 20'h00010, 32'hDEADBEEF);

    // 3. fill to full, overflow ignored, in-order drain
    wr_log.delete();
    mem_busy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      st_valid = 1'b1; st_addr = 20'(i); st_data = 32'(i * 32'h100);
      tick();
    end
    check("t3_full_count", count, 4);
    check("t3_full_ready", st_ready, 0);
    st_addr = 20'h5; st_data = 32'h500;
    tick();
    check("t3_overflow_count", count, 4);
    mem_busy = 1'b0;
    settle();
    check("t3_full_drain_ready", st_ready, 0);
    for (int i = 1; i <= 4; i++) begin
      settle();
      check($sformatf("t3_we%0d", i), mem_we, 1);
      check($sformatf("t3_adr%0d", i), mem_adr, 20'(i));
      tick();
      st_valid = 1'b0;
    end
    check("t3_empty", empty, 1);
    check("t3_nwrites", wr_log.size(), 4);
    for (int i = 0; i < 4; i++)
      expect_log($sformatf("t3_w%0d", i), i, 20'(i + 1), 32'((i + 1) * 32'h100));

    // 4. duplicate addresses: youngest wins, both drain in order
    wr_log.delete();
    mem_busy = 1'b1;
    ld_addr  = 20'h00020;
    st_valid = 1'b1; st_addr = 20'h00020; st_data = 32'h11;
    tick();
    st_data = 32'h22;
    tick();
    st_valid = 1'b0;
    settle();
    check("t4_hit", ld_hit, 1);
    check("t4_youngest", ld_data, 32'h22);
    mem_busy = 1'b0;
    tick();
    check("t4_after1_count", count, 1);
    check("t4_after1_data", ld_data, 32'h22);
    tick();
    check("t4_empty", empty, 1);
    check("t4_miss", ld_hit, 0);
    check("t4_miss_data", ld_data, 0);
    expect_log("t4_w0", 0, 20'h00020, 32'h11);
    expect_log("t4_w1", 1, 20'h00020, 32'h22);

    // 5. steady stream with pointer wrap
    wr_log.delete();
    mem_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      st_valid = 1'b1; st_addr = 20'(20'h100 + i); st_data = 32'(32'hA0 + i);
      tick();
      check($sformatf("t5_count%0d", i), count, 1);
      check($sformatf("t5_we%0d", i), mem_we, 1);
    end
    st_valid = 1'b0;
    tick();
    check("t5_empty", empty, 1);
    check("t5_nwrites", wr_log.size(), 10);
    for (int i = 0; i < 10; i++)
      expect_log($sformatf("t5_w%0d", i), i, 20'(20'h100 + i), 32'(32'hA0 + i));

    // 6. reset mid-operation discards queued stores
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      st_valid = 1'b1; st_addr = 20'(20'h200 + i); st_data = 32'(i);
      tick();
    end
    st_valid = 1'b0;
    settle();
    check("t6_count", count, 3);
    wr_log.delete();
    reset = 1'b0;
    settle();
    check("t6_rst_empty", empty, 1);
    check("t6_rst_count", count, 0);
    check("t6_rst_we", mem_we, 0);
    check("t6_rst_adr", mem_adr, 0);
    check("t6_rst_ready", st_ready, 0);
    mem_busy = 1'b0;
    tick();
    reset = 1'b1;
    tick(); tick(); tick();
    check("t6_post_empty", empty, 1);
    check("t6_post_nwrites", wr_log.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
